// File: rtl/alu_issue.sv
// Issue/writeback stage feeding the combinational 8-bit alu: owns an 8x8 register file,
// registers operands at accept, writes the ALU result back one cycle later. Option: ALU_ISSUE_R0_ZERO_EN.
module alu_issue #(
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] REG_RESET = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        instr_op,
   input  logic [2:0]        instr_rd,
   input  logic [2:0]        instr_rs,
   input  logic [2:0]        instr_rt,
   input  logic              instr_imm_sel,
   input  logic [DATA_W-1:0] instr_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              wb_valid,
   output logic [2:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_zero,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic              dbg_state
);

   // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
   // instr_valid while instr_ready is low is ignored and may change freely.
   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_accept;
   logic              w_wb;
   logic              w_wr_en;
   logic [2:0]        r_rd;
   logic [DATA_W-1:0] r_regs [8];

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (instr_valid) w_next = EXEC;
         EXEC:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      instr_ready = (r_state == IDLE);
      w_accept    = (r_state == IDLE) && instr_valid;
      w_wb        = (r_state == EXEC);
      dbg_state   = r_state;
   end

`ifdef ALU_ISSUE_R0_ZERO_EN
   assign w_wr_en  = w_wb && (r_rd != 3'd0);
   assign dbg_data = (dbg_addr == 3'd0) ? '0 : r_regs[dbg_addr];
`else
   assign w_wr_en  = w_wb;
   assign dbg_data = r_regs[dbg_addr];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= 3'b000;
         r_rd       <= 3'd0;
         wb_valid   <= 1'b0;
         wb_rd      <= 3'd0;
         wb_data    <= '0;
         wb_zero    <= 1'b0;
      end else begin
         if (w_accept) begin
            alu_a      <= r_regs[instr_rs];
            alu_b      <= instr_imm_sel ? instr_imm : r_regs[instr_rt];
            alu_opcode <= instr_op;
            r_rd       <= instr_rd;
         end
         wb_valid <= w_wb;
         if (w_wb) begin
            wb_rd   <= r_rd;
            wb_data <= alu_result;
            wb_zero <= alu_zero;
         end
      end
   end

   // Writeback lands on the same edge the FSM returns to IDLE, so no forwarding is needed.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) r_regs[i] <= REG_RESET;
`ifdef ALU_ISSUE_R0_ZERO_EN
         r_regs[0] <= '0;
`endif
      end else if (w_wr_en) begin
         r_regs[r_rd] <= alu_result;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU, register-file model and writeback scoreboard.
module tb_alu_issue;

  localparam logic [7:0] REG_RESET = 8'h00;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SL = 3'd5;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op, instr_rd, instr_rs, instr_rt;
  logic       instr_imm_sel;
  logic [7:0] instr_imm;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       wb_zero;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       dbg_state;

  int n_vec  = 0;
  int n_fail = 0;
  int wb_cnt = 0;
  int push_cnt = 0;

  logic [7:0]  m_regs [8];
  logic [11:0] exp_q [$];   // {rd, zero, data}

  alu_issue #(.DATA_W(8), .REG_RESET(REG_RESET)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .instr_imm_sel(instr_imm_sel), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_zero(wb_zero),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU environment ----------------
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    alu_fn = a + b;
      3'd1:    alu_fn = a - b;
      3'd2:    alu_fn = a & b;
      3'd3:    alu_fn = a | b;
      3'd4:    alu_fn = a ^ b;
      3'd5:    alu_fn = {a[6:0], 1'b0};
      3'd6:    alu_fn = {1'b0, a[7:1]};
      default: alu_fn = b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_opcode, alu_a, alu_b);
  assign alu_zero   = (alu_result == 8'h00);

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard model ----------------
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = REG_RESET;
`ifdef ALU_ISSUE_R0_ZERO_EN
    m_regs[0] = 8'h00;
`endif
  endtask

  // Computes the expected writeback from the model, queues it, updates the model.
  task automatic model_push(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                            input logic [2:0] rt, input logic sel, input logic [7:0] imm,
                            output logic [7:0] exp_a);
    logic [7:0] b, r;
    exp_a = m_regs[rs];
    b     = sel ? imm : m_regs[rt];
    r     = alu_fn(op, exp_a, b);
    exp_q.push_back({rd, (r == 8'h00), r});
    push_cnt++;
`ifdef ALU_ISSUE_R0_ZERO_EN
    if (rd != 3'd0) m_regs[rd] = r;
`else
    m_regs[rd] = r;
`endif
  endtask

  always @(negedge clk) begin
    if (wb_valid) begin
      logic [11:0] e;
      wb_cnt++;
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb_rd",   wb_rd,   e[11:9]);
        check("wb_zero", wb_zero, e[8]);
        check("wb_data", wb_data, e[7:0]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic sel, input logic [7:0] imm);
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
    instr_imm_sel = sel; instr_imm = imm; instr_valid = 1'b1;
  endtask

  // Issues one instruction from a negedge, checks 2-cycle latency and the held operand A.
  task automatic run_one(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic sel, input logic [7:0] imm);
    logic [7:0] exp_a;
    int waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_issue", instr_ready, 1'b1);
    model_push(op, rd, rs, rt, sel, imm, exp_a);
    drive(op, rd, rs, rt, sel, imm);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("lat_no_wb_yet", wb_valid, 1'b0);
    check("exec_not_ready", instr_ready, 1'b0);
    @(negedge clk);
    check("lat_wb_pulse", wb_valid, 1'b1);
    check("alu_a_held", alu_a, exp_a);
    dbg_addr = rd;
    #1 check("dbg_rd", dbg_data, m_regs[rd]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ea;
    int base_cnt;
    reset = 1'b1; instr_valid = 1'b0;
    instr_op = '0; instr_rd = '0; instr_rs = '0; instr_rt = '0;
    instr_imm_sel = 1'b0; instr_imm = '0; dbg_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_ready", instr_ready, 1'b1);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_opcode", alu_opcode, 3'b000);
    check("rst_wb", {wb_valid, wb_rd, wb_data, wb_zero}, 13'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 check("rst_reg", dbg_data, m_regs[i]);
    end
    @(negedge clk);

    // directed cases
    run_one(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05);
    check("r1_is_5", dbg_data, 8'h05);
    run_one(OP_SUB, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00);
    run_one(OP_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 8'h80);
    run_one(OP_SL,  3'd3, 3'd3, 3'd0, 1'b1, 8'h00);
    check("sl_wrap_r3", dbg_data, 8'h00);
    run_one(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 8'hFF);
    run_one(OP_ADD, 3'd4, 3'd4, 3'd0, 1'b1, 8'h01);
    check("add_wrap_r4", dbg_data, 8'h00);
    run_one(OP_ADD, 3'd7, 3'd7, 3'd7, 1'b0, 8'h00);

    // streaming: valid held for 6 cycles, dependent r5 += 1 chain
    @(negedge clk);
    base_cnt = wb_cnt;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      check("stream_ready", instr_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
      if (instr_ready) model_push(OP_ADD, 3'd5, 3'd5, 3'd0, 1'b1, 8'h01, ea);
      drive(OP_ADD, 3'd5, 3'd5, 3'd0, 1'b1, 8'h01);
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    #1;
    check("stream_wb_count", wb_cnt - base_cnt, 3);
    dbg_addr = 3'd5;
    #1 check("stream_r5", dbg_data, 8'h03);

    // random instructions
    for (int n = 0; n < 10; n++) begin
      run_one(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    // reset while in EXEC discards the instruction
    @(negedge clk);
    base_cnt = wb_cnt;
    drive(OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 8'h33);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("rst_exec_busy", instr_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst_exec_no_wb", wb_valid, 1'b0);
    check("rst_exec_ready", instr_ready, 1'b1);
    @(negedge clk);
    check("rst_exec_no_wb_later", wb_cnt - base_cnt, 0);
    dbg_addr = 3'd6;
    #1 check("rst_exec_r6", dbg_data, REG_RESET);
    dbg_addr = 3'd1;
    #1 check("rst_exec_r1", dbg_data, REG_RESET);

    // r0 write
    @(negedge clk);
    run_one(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 8'h7A);
`ifdef ALU_ISSUE_R0_ZERO_EN
    check("r0_value", dbg_data, 8'h00);
`else
    check("r0_value", dbg_data, 8'h7A);
`endif

    repeat (3) @(negedge clk);
    check("wb_total", wb_cnt, push_cnt);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
